// File: rtl/sbox_pipe.sv
// sbox_pipe: two-stage pipelined AES byte substitution over LANES byte lanes.
//
// Each transfer carries LANES bytes and a mode bit. Stage 1 registers the
// input bytes and the effective mode; the S-box lookup sits between the
// stages; stage 2 registers the substituted bytes and the mode, and drives the
// outputs directly.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      asynchronous, active-high reset
//   in_valid   upstream offers a transfer
//   in_ready   block accepts a transfer this cycle
//   in_data    input lanes, lane i = in_data[8i+7:8i]
//   in_inv     1 = inverse S-box for this transfer (ignored when INV_EN = 0)
//   out_valid  result available
//   out_ready  downstream consumes the result
//   out_data   substituted lanes, same ordering as in_data
//   out_inv    mode actually applied to out_data
//
// Handshake: a transfer moves across an interface on a rising edge where
// valid and ready are both 1. Once valid is raised, the offering side keeps
// valid and its payload unchanged until that edge; ready may depend
// combinationally on the downstream ready, but valid never depends on ready.
module sbox_pipe #(
    parameter int LANES  = 4,
    parameter int INV_EN = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic                 in_inv,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic                 out_inv
);

    localparam int DW = 8 * LANES;

    // Forward table, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_ROM = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Inverse table, same layout.
    localparam logic [2047:0] INV_SBOX_ROM = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Entry b lives at bit offset (255 - b) * 8 = {~b, 3'b000}.
    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        logic [10:0] idx;
        idx = {~b, 3'b000};
        return SBOX_ROM[idx +: 8];
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] b);
        logic [10:0] idx;
        idx = {~b, 3'b000};
        return INV_SBOX_ROM[idx +: 8];
    endfunction

    logic          s1_valid;
    logic [DW-1:0] s1_data;
    logic          s1_inv;
    logic          s2_valid;
    logic [DW-1:0] s2_data;
    logic          s2_inv;

    logic          adv1;
    logic          adv2;
    logic          eff_inv;
    logic [DW-1:0] sub_data;

    // A stage may load when it is empty or its contents move on this edge.
    assign adv2 = !s2_valid || out_ready;
    assign adv1 = !s1_valid || adv2;

    // Gated by reset so the block refuses input for the whole reset interval.
    assign in_ready = adv1 && !reset;

    // With the inverse path disabled the mode is tied low, so the inverse
    // table has no reachable use and drops out of the netlist.
    assign eff_inv = (INV_EN != 0) ? in_inv : 1'b0;

    always_comb begin
        sub_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (s1_inv) begin
                sub_data[8*i +: 8] = sbox_inv(s1_data[8*i +: 8]);
            end else begin
                sub_data[8*i +: 8] = sbox_fwd(s1_data[8*i +: 8]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_inv   <= 1'b0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_inv   <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid <= in_valid;
                // Payload only changes when a transfer is actually taken.
                if (in_valid) begin
                    s1_data <= in_data;
                    s1_inv  <= eff_inv;
                end
            end
            if (adv2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= sub_data;
                    s2_inv  <= s1_inv;
                end
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_inv   = s2_inv;

endmodule
